ulpi_reg_arb: RTL
=================

# ulpi_reg_arb

Round-robin arbiter and sequencer for ULPI PHY register access. It shares the link-side ULPI bus between N requesters, such as the enumeration logic and the debug/config path, and runs immediate register write and read transactions on that bus. It yields to PHY-initiated traffic (`i_dir`) and retries aborted transactions. It sits beside `ulpi_ctrl` and takes the ULPI bus only after `ulpi_ctrl` reports the PHY reset sequence complete (`i_link_ready`).

## Interface
- `N_REQ`, 2: number of requesters (≥1).
- `MAX_RETRY`, 4: aborts tolerated per transaction before error completion.
- `TIMEOUT`, 255: max cycles spent in any PHY-wait state before error completion.

- `i_clk`  in  1  sole clock (ULPI 60 MHz).
- `i_rst`  in  1  synchronous, active-high reset.
- `i_link_ready`  in  1  high once `ulpi_ctrl` has finished PHY reset; low = bus unavailable.
- `i_req`  in  N_REQ  per-requester request level.
- `i_we`  in  N_REQ  1 = register write, 0 = register read.
- `i_addr`  in  N_REQ*6  register address; requester k at [6k+5:6k].
- `i_wdata`  in  N_REQ*8  write data; requester k at [8k+7:8k].
- `o_ack`  out  N_REQ  one-cycle completion pulse to the granted requester.
- `o_err`  out  1  valid with `o_ack`; 1 = transaction failed.
- `o_rdata`  out  8  read result, valid with `o_ack` for reads.
- `i_dir`, `i_nxt`  in  1 each  ULPI PHY direction and next.
- `i_data`  in  8  ULPI data from PHY.
- `o_data`  out  8  ULPI data to PHY.
- `o_data_oe`  out  1  link drives data bus.
- `o_stp`  out  1  ULPI stop.

## Operation
- Requester contract: hold `i_req`, `i_we`, `i_addr` and `i_wdata` stable until `o_ack`. A requester whose `o_ack` is high this cycle is not eligible for grant this cycle.
- Arbitration happens in IDLE only when `i_link_ready=1` and `i_dir=0`.
  - The search starts at index `last_grant+1` and wraps modulo N_REQ.
  - The grant, `we`, `addr` and `wdata` are latched.
  - The grant stays locked through retries until `o_ack`.
- States and their outputs:
  - IDLE: `oe=0`, `data=0`, `stp=0`.
  - CMD: `oe=1`, `o_data={we?2'b10:2'b11, addr}`.
    - `i_dir=1` → ABORT.
    - Otherwise `i_nxt=1` → WDATA (write) or RTURN (read).
  - WDATA: `oe=1`, `o_data=wdata`.
    - `i_dir=1` → ABORT.
    - Otherwise `i_nxt=1` → WSTP.
  - WSTP: `oe=1`, `o_data=0`, `o_stp=1` for exactly one cycle → DONE.
  - RTURN: `oe=0`. Waits for `i_dir=1` (turnaround cycle) → RDATA.
  - RDATA:
    - `i_dir=1 & i_nxt=0`: capture `i_data` into `o_rdata` → RWAIT.
    - `i_dir=1 & i_nxt=1` (RX CMD pre-empts read) → ABORT.
    - `i_dir=0` → ABORT.
  - RWAIT: waits for `i_dir=0` → DONE.
  - ABORT: `oe=0`; `retry` increments.
    - If `retry==MAX_RETRY` → DONE with error.
    - Otherwise → IDLE, with the grant kept locked.
  - DONE: one cycle; registers the `o_ack`/`o_err` pulse → IDLE.
- `i_link_ready` falling in any non-IDLE state forces `oe=0` and `stp=0` immediately (same cycle, registered next edge) → DONE with `err=1`.
- Watchdog: the timeout counter resets on entry to CMD, RTURN and RWAIT. Reaching TIMEOUT → DONE with `err=1`.
- Extended register addressing (addr 6'h2F) is not supported; it is passed through as a plain address.

## Timing
- Reset values:
  - Outputs: `o_stp=0`, `o_data=0`, `o_data_oe=0`, `o_ack=0`, `o_err=0`, `o_rdata=0`.
  - Internal: state IDLE, `last_grant=N_REQ-1` (requester 0 wins first), retry 0, timeout counter 0.
- All outputs are registered.
- Write with immediate `i_nxt`: req seen in IDLE at cycle 0; CMD cycle 1; WDATA cycle 2; WSTP cycle 3; `o_ack` cycle 4. Minimum write latency is 4 cycles.
- Read with PHY turnaround: CMD (nxt) cycle 1; RTURN cycle 2 (dir rises); RDATA cycle 3; RWAIT cycle 4 (dir falls); `o_ack` cycle 5, `o_rdata` valid.
- Reset asserted mid-transaction: all outputs return to reset values at the next edge. No `o_ack` is issued.
- Simultaneous requests: exactly one grant per IDLE arbitration. Two requesters held high alternate strictly.

## Test plan
- Write, req0: `addr=6'h0A`, `wdata=8'h55`, PHY asserts nxt immediately → `o_data` sequence 8'h8A, 8'h55, 8'h00 with `o_stp=1` on the third cycle; `o_ack=2'b01` and `o_err=0` on the fourth cycle.
- Read, req1: `addr=6'h00`, PHY returns 8'h24 → `o_data`=8'hC0 in CMD; `o_ack=2'b10`, `o_rdata=8'h24`, `o_err=0`.
- Both requesting continuously (writes) → grants 0,1,0,1; ack order matches.
- `i_dir` asserted during CMD on the first 2 attempts, clean 3rd attempt → transaction completes, `o_err=0`. `i_dir` asserted on every attempt → `o_ack` with `o_err=1` after 4 aborts.
- `i_link_ready=0` with req high → no bus activity (`o_data_oe=0`). `i_link_ready` dropped during WDATA → `o_data_oe=0` next cycle, then ack with `o_err=1`.
- Read where PHY never asserts dir after nxt → error ack after 255 cycles in RTURN. `i_rst` pulsed mid-read → all outputs 0, state IDLE.

Source files
------------

// File: rtl/ulpi_reg_arb.sv
// Round-robin arbiter and sequencer for ULPI immediate register writes/reads.
// Yields to PHY traffic, retries aborted transactions, and enforces a PHY-wait watchdog.
//
// state | meaning
// IDLE  | bus idle; arbitrate, or reissue the locked grant after an abort
// CMD   | drive TX CMD byte, wait for nxt
// WDATA | drive write data, wait for nxt
// WSTP  | drive stp for one cycle
// RTURN | wait for PHY turnaround (dir rising)
// RDATA | sample read data
// RWAIT | wait for PHY to release the bus (dir falling)
// ABORT | PHY pre-empted the transaction; count a retry
// DONE  | one-cycle ack/err pulse
module ulpi_reg_arb #(
  parameter int N_REQ     = 2,
  parameter int MAX_RETRY = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_link_ready,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ-1:0]   i_we,
  input  logic [N_REQ*6-1:0] i_addr,
  input  logic [N_REQ*8-1:0] i_wdata,
  output logic [N_REQ-1:0]   o_ack,
  output logic               o_err,
  output logic [7:0]         o_rdata,
  input  logic               i_dir,
  input  logic               i_nxt,
  input  logic [7:0]         i_data,
  output logic [7:0]         o_data,
  output logic               o_data_oe,
  output logic               o_stp
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, CMD, WDATA, WSTP, RTURN, RDATA, RWAIT, ABORT, DONE
  } state_t;

  state_t state, state_next;

  logic [GW-1:0]    grant_q, grant_d, last_grant_q, last_grant_d;
  logic             locked_q, locked_d;
  logic             we_q, we_d;
  logic [5:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [TW-1:0]    wd_q, wd_d;
  logic             done_err;
  logic [N_REQ-1:0] eligible;
  logic [GW-1:0]    idx_v, pick;
  logic             found;
  logic [N_REQ-1:0] ack_d;
  logic             err_d, oe_d, stp_d;
  logic [7:0]       data_d, rdata_d;

  always_comb begin
    state_next   = state;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    locked_d     = locked_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    retry_d      = retry_q;
    rdata_d      = o_rdata;
    done_err     = 1'b0;
    found        = 1'b0;
    pick         = '0;
    idx_v        = '0;
    eligible     = i_req & ~o_ack;

    // round-robin search starting just after the last winner
    for (int i = 0; i < N_REQ; i++) begin
      idx_v = GW'((int'(last_grant_q) + 1 + i) % N_REQ);
      if (!found && eligible[idx_v]) begin
        found = 1'b1;
        pick  = idx_v;
      end
    end

    case (state)
      IDLE: begin
        if (i_link_ready && !i_dir) begin
          if (locked_q) begin
            state_next = CMD;
          end else if (found) begin
            state_next   = CMD;
            locked_d     = 1'b1;
            grant_d      = pick;
            last_grant_d = pick;
            we_d         = i_we[pick];
            addr_d       = i_addr[int'(pick)*6 +: 6];
            wdata_d      = i_wdata[int'(pick)*8 +: 8];
            retry_d      = '0;
          end
        end
      end
      CMD: begin
        if (i_dir)               state_next = ABORT;
        else if (i_nxt)          state_next = we_q ? WDATA : RTURN;
        else if (wd_q == '0) begin
          state_next = DONE;
          done_err   = 1'b1;
        end
      end
      WDATA: begin
        if (i_dir)               state_next = ABORT;
        else if (i_nxt)          state_next = WSTP;
        else if (wd_q == '0) begin
          state_next = DONE;
          done_err   = 1'b1;
        end
      end
      WSTP: state_next = DONE;
      RTURN: begin
        if (i_dir)               state_next = RDATA;
        else if (wd_q == '0) begin
          state_next = DONE;
          done_err   = 1'b1;
        end
      end
      RDATA: begin
        if (i_dir && !i_nxt) begin
          rdata_d    = i_data;
          state_next = RWAIT;
        end else begin
          state_next = ABORT;
        end
      end
      RWAIT: begin
        if (!i_dir)              state_next = DONE;
        else if (wd_q == '0) begin
          state_next = DONE;
          done_err   = 1'b1;
        end
      end
      ABORT: begin
        retry_d = retry_q + RW'(1);
        if (retry_q == RW'(MAX_RETRY - 1)) begin
          state_next = DONE;
          done_err   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      DONE: begin
        state_next = IDLE;
        locked_d   = 1'b0;
        retry_d    = '0;
      end
      default: state_next = IDLE;
    endcase

    // losing the link mid-transaction releases the bus and fails the request
    if (state != IDLE && state != DONE && !i_link_ready) begin
      state_next = DONE;
      done_err   = 1'b1;
      rdata_d    = o_rdata;
    end

    wd_d = wd_q;
    if ((state_next == CMD || state_next == RTURN || state_next == RWAIT) && state_next != state)
      wd_d = TW'(TIMEOUT - 1);
    else if (wd_q != '0)
      wd_d = wd_q - TW'(1);

    // outputs are registered, so decode them from the state being entered
    ack_d  = '0;
    err_d  = 1'b0;
    oe_d   = 1'b0;
    stp_d  = 1'b0;
    data_d = '0;
    case (state_next)
      CMD: begin
        oe_d   = 1'b1;
        data_d = {(we_d ? 2'b10 : 2'b11), addr_d};
      end
      WDATA: begin
        oe_d   = 1'b1;
        data_d = wdata_d;
      end
      WSTP: begin
        oe_d  = 1'b1;
        stp_d = 1'b1;
      end
      DONE: begin
        ack_d[grant_d] = 1'b1;
        err_d          = done_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant_q      <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      locked_q     <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      retry_q      <= '0;
      wd_q         <= '0;
      o_ack        <= '0;
      o_err        <= 1'b0;
      o_data       <= '0;
      o_data_oe    <= 1'b0;
      o_stp        <= 1'b0;
      o_rdata      <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      locked_q     <= locked_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      retry_q      <= retry_d;
      wd_q         <= wd_d;
      o_ack        <= ack_d;
      o_err        <= err_d;
      o_data       <= data_d;
      o_data_oe    <= oe_d;
      o_stp        <= stp_d;
      o_rdata      <= rdata_d;
    end
  end

endmodule
